// File: rtl/mole_game_pkg.sv
// Shared types, constants and arithmetic helpers for the whack-a-mole game sequencer.
package mole_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } game_state_t;

   // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int          NUM_MOLES_DEF   = 4;
   localparam int          TICK_DIV_DEF    = 1000000;
   localparam int          MOLE_LIFE_DEF   = 150;
   localparam int          SPAWN_GAP_DEF   = 40;
   localparam int          ROUND_TICKS_DEF = 3000;
   localparam int          SCORE_W_DEF     = 8;
   localparam logic [15:0] LFSR_SEED_DEF   = 16'hACE1;

   // Number of set bits in a 4-bit hole vector
   function automatic logic [3:0] pop4(input logic [3:0] v);
      return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]};
   endfunction

   // Add a small signed delta to a counter, clamping to [0, max_val]
   function automatic logic [15:0] sat_step(input logic [15:0]        val,
                                            input logic signed [4:0] delta,
                                            input logic [15:0]        max_val);
      logic signed [17:0] sum_v;
      sum_v = $signed({2'b00, val}) + $signed({{13{delta[4]}}, delta});
      if (sum_v < 18'sd0) begin
         return 16'h0000;
      end else if (sum_v > $signed({2'b00, max_val})) begin
         return max_val;
      end else begin
         return sum_v[15:0];
      end
   endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr.sv
// 16-bit Galois LFSR used as the random source for spawn hole selection.
module mole_lfsr
   import mole_game_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_r;
   logic [15:0] lfsr_next_s;

   // Next state: shift right, fold the tap mask in when the outgoing bit is 1
   always_comb begin
      lfsr_next_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
   end

   // State register, seeded on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_r <= SEED;
      end else if (en) begin
         lfsr_r <= lfsr_next_s;
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign lfsr = lfsr_r;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: round timer, spawn scheduling, mole lifetimes and scoring.
module mole_game_ctrl
   import mole_game_pkg::*;
#(
   parameter int          NUM_MOLES   = NUM_MOLES_DEF,
   parameter int          TICK_DIV    = TICK_DIV_DEF,
   parameter int          MOLE_LIFE   = MOLE_LIFE_DEF,
   parameter int          SPAWN_GAP   = SPAWN_GAP_DEF,
   parameter int          ROUND_TICKS = ROUND_TICKS_DEF,
   parameter int          SCORE_W     = SCORE_W_DEF,
   parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] hit,
   output logic [NUM_MOLES-1:0] mole,
   output logic [SCORE_W-1:0]   score,
   output logic [SCORE_W-1:0]   misses,
   output logic [11:0]          time_left,
   output logic [1:0]           game_state,
   output logic                 game_over
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LIFE_W = $clog2(MOLE_LIFE + 1);
   localparam int GAP_W  = $clog2(SPAWN_GAP + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   game_state_t        state_r;
   logic [DIV_W-1:0]   div_r;
   logic               start_d_r;
   logic [3:0]         hit_d_r;
   logic [3:0]         mole_r;
   logic [SCORE_W-1:0] score_r;
   logic [SCORE_W-1:0] misses_r;
   logic [11:0]        time_left_r;
   logic               game_over_r;
   logic [GAP_W-1:0]   spawn_cnt_r;
   logic [LIFE_W-1:0]  life_r [4];

   logic               tick_s;
   logic               start_rise_s;
   logic [3:0]         hit_rise_s;
   logic [15:0]        lfsr_s;
   logic               lfsr_unused_s;
   logic [3:0]         good_s;
   logic [3:0]         bad_s;
   logic [3:0]         expire_s;
   logic [3:0]         spawn_mask_s;
   logic [3:0]         mole_next_s;
   logic               spawn_ev_s;
   logic               round_end_s;
   logic               found_s;
   logic [1:0]         probe_s;
   logic signed [4:0]  delta_s;
   logic [SCORE_W-1:0] score_next_s;
   logic [SCORE_W-1:0] misses_next_s;

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .lfsr  (lfsr_s)
   );

   // Only the two low LFSR bits pick a hole
   assign lfsr_unused_s = ^lfsr_s[15:2];

   assign tick_s       = (div_r == DIV_W'(TICK_DIV - 1));
   assign start_rise_s = start & ~start_d_r;
   assign hit_rise_s   = hit & ~hit_d_r;

   // Per-cycle play decisions: hits, expiries, spawn target and score deltas
   always_comb begin
      good_s       = 4'b0000;
      bad_s        = 4'b0000;
      expire_s     = 4'b0000;
      spawn_mask_s = 4'b0000;
      spawn_ev_s   = 1'b0;
      round_end_s  = 1'b0;
      found_s      = 1'b0;
      probe_s      = 2'b00;
      if (state_r == ST_PLAY) begin
         good_s      = hit_rise_s & mole_r;
         bad_s       = hit_rise_s & ~mole_r;
         spawn_ev_s  = tick_s && (spawn_cnt_r == GAP_W'(SPAWN_GAP - 1));
         round_end_s = tick_s && (time_left_r == 12'd1);
         // A hit on an expiring hole takes priority, so expiry excludes good hits
         for (int k = 0; k < 4; k++) begin
            expire_s[k] = tick_s & mole_r[k] & ~good_s[k] & (life_r[k] == LIFE_W'(1));
         end
         // Only holes empty at cycle start are eligible, searched from the random index
         for (int k = 0; k < 4; k++) begin
            probe_s = lfsr_s[1:0] + 2'(k);
            if (spawn_ev_s && !found_s && !mole_r[probe_s]) begin
               spawn_mask_s[probe_s] = 1'b1;
               found_s               = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         spawn_ev_s = 1'b0;
      end
      mole_next_s   = (mole_r & ~good_s & ~expire_s) | spawn_mask_s;
      delta_s       = $signed({1'b0, pop4(good_s)}) - $signed({1'b0, pop4(bad_s)});
      score_next_s  = SCORE_W'(sat_step(16'(score_r), delta_s, 16'(SCORE_MAX)));
      misses_next_s = SCORE_W'(sat_step(16'(misses_r), $signed({1'b0, pop4(expire_s)}),
                                        16'(SCORE_MAX)));
   end

   // Game FSM with tick divider, edge history, round timer and mole bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         div_r       <= '0;
         start_d_r   <= 1'b0;
         hit_d_r     <= 4'b0000;
         mole_r      <= 4'b0000;
         score_r     <= '0;
         misses_r    <= '0;
         time_left_r <= 12'd0;
         game_over_r <= 1'b0;
         spawn_cnt_r <= '0;
         for (int k = 0; k < 4; k++) begin
            life_r[k] <= '0;
         end
      end else begin
         start_d_r <= start;
         hit_d_r   <= hit;
         div_r     <= tick_s ? '0 : div_r + DIV_W'(1);
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_rise_s) begin
                  state_r     <= ST_PLAY;
                  time_left_r <= 12'(ROUND_TICKS);
                  score_r     <= '0;
                  misses_r    <= '0;
                  mole_r      <= 4'b0000;
                  spawn_cnt_r <= '0;
                  game_over_r <= 1'b0;
               end else begin
                  mole_r <= 4'b0000;
               end
            end
            ST_PLAY: begin
               score_r  <= score_next_s;
               misses_r <= misses_next_s;
               if (tick_s) begin
                  time_left_r <= (time_left_r != 12'd0) ? time_left_r - 12'd1 : 12'd0;
                  spawn_cnt_r <= spawn_ev_s ? '0 : spawn_cnt_r + GAP_W'(1);
                  for (int k = 0; k < 4; k++) begin
                     if (spawn_mask_s[k]) begin
                        life_r[k] <= LIFE_W'(MOLE_LIFE);
                     end else if (mole_r[k] && (life_r[k] != '0)) begin
                        life_r[k] <= life_r[k] - LIFE_W'(1);
                     end else begin
                        life_r[k] <= life_r[k];
                     end
                  end
               end else begin
                  spawn_cnt_r <= spawn_cnt_r;
               end
               if (round_end_s) begin
                  state_r     <= ST_DONE;
                  mole_r      <= 4'b0000;
                  game_over_r <= 1'b1;
               end else begin
                  mole_r <= mole_next_s;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               mole_r      <= 4'b0000;
               game_over_r <= 1'b0;
            end
         endcase
      end
   end

   assign mole       = mole_r;
   assign score      = score_r;
   assign misses     = misses_r;
   assign time_left  = time_left_r;
   assign game_state = state_r;
   assign game_over  = game_over_r;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: a short-round instance for timing/scoring/expiry
// and a fast-spawn, long-life instance for full-board and mid-round reset cases.
module tb_mole_game_ctrl;

   logic        clk;
   logic        reset;
   logic        start,  start2;
   logic [3:0]  hit,    hit2;
   logic [3:0]  mole,   mole2;
   logic [7:0]  score,  score2;
   logic [7:0]  misses, misses2;
   logic [11:0] time_left, time_left2;
   logic [1:0]  game_state, game_state2;
   logic        game_over, game_over2;

   int n_cmp;
   int n_err;

   logic [15:0] m_lfsr;
   logic [1:0]  m_div;
   logic [1:0]  idx, idx_a, idx_b, idx_c, idx_d, idx_e;

   mole_game_ctrl #(
      .TICK_DIV(4), .MOLE_LIFE(5), .SPAWN_GAP(3), .ROUND_TICKS(50)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .hit(hit), .mole(mole), .score(score),
      .misses(misses), .time_left(time_left), .game_state(game_state), .game_over(game_over)
   );

   mole_game_ctrl #(
      .TICK_DIV(4), .MOLE_LIFE(60), .SPAWN_GAP(1), .ROUND_TICKS(200)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start2), .hit(hit2), .mole(mole2), .score(score2),
      .misses(misses2), .time_left(time_left2), .game_state(game_state2),
      .game_over(game_over2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [3:0] oh(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   function automatic logic [1:0] first_empty(input logic [3:0] m, input logic [1:0] i);
      logic [1:0] j;
      first_empty = i;
      for (int k = 3; k >= 0; k--) begin
         j = i + 2'(k);
         if (!m[j]) first_empty = j;
      end
   endfunction

   // Reference LFSR and tick-divider phase, both free-running from reset
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_lfsr <= 16'hACE1;
         m_div  <= 2'd0;
      end else begin
         m_lfsr <= lfsr_step(m_lfsr);
         m_div  <= m_div + 2'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Advance to the negedge right before a tick edge
   task automatic pre_tick();
      for (int n = 0; n < 8 && m_div != 2'd3; n++) step();
      if (m_div != 2'd3) chk("tick_bound", 32'(m_div), 32'd3);
   endtask

   // Run through the next tick edge, returning the LFSR hole index used on it
   task automatic tick(output logic [1:0] i);
      pre_tick();
      i = m_lfsr[1:0];
      step();
   endtask

   task automatic align();
      for (int n = 0; n < 8 && m_div != 2'd0; n++) step();
      if (m_div != 2'd0) chk("align_bound", 32'(m_div), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; start = 1'b0; start2 = 1'b0; hit = 4'b0000; hit2 = 4'b0000;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mole",   32'(mole),       32'd0);
      chk("rst_score",  32'(score),      32'd0);
      chk("rst_misses", 32'(misses),     32'd0);
      chk("rst_time",   32'(time_left),  32'd0);
      chk("rst_state",  32'(game_state), 32'd0);
      chk("rst_over",   32'(game_over),  32'd0);
      chk("rst_lfsr",   32'(dut.u_lfsr.lfsr_r), 32'h0000ACE1);
      reset = 1'b1;
      step();
      chk("lfsr_adv", 32'(dut.u_lfsr.lfsr_r), 32'(m_lfsr));
      align();

      // Round start, then a penalty hit with nothing up at score 0
      start = 1'b1; step();
      chk("start_state", 32'(game_state), 32'd1);
      chk("start_time",  32'(time_left),  32'd50);
      start = 1'b0; hit = 4'b0001; step();
      chk("pen_floor", 32'(score), 32'd0);
      hit = 4'b0000;
      tick(idx);   // T1
      chk("time_t1", 32'(time_left), 32'd49);
      tick(idx);   // T2
      chk("no_spawn_t2", 32'(mole), 32'd0);
      tick(idx_a); // T3 spawn into empty board
      chk("spawn1", 32'(mole), 32'(oh(idx_a)));
      chk("time_t3", 32'(time_left), 32'd47);

      // Good hit, good hit, then penalty from 2 down to 1
      hit = oh(idx_a); step();
      chk("hit_clear", 32'(mole),  32'd0);
      chk("hit_score", 32'(score), 32'd1);
      hit = 4'b0000;
      tick(idx); tick(idx);
      tick(idx_b); // T6
      chk("spawn2", 32'(mole), 32'(oh(idx_b)));
      hit = oh(idx_b); step();
      chk("hit2_score", 32'(score), 32'd2);
      hit = oh(idx_b + 2'd1); step();
      chk("pen_dec", 32'(score), 32'd1);
      hit = 4'b0000;

      // Expiry: C up at T9, second mole at T12, C escapes at T14
      tick(idx); tick(idx);
      tick(idx_c); // T9
      chk("spawn3", 32'(mole), 32'(oh(idx_c)));
      tick(idx); tick(idx);
      tick(idx);   // T12
      idx_d = first_empty(oh(idx_c), idx);
      chk("spawn_two", 32'(mole), 32'(oh(idx_c) | oh(idx_d)));
      tick(idx);   // T13, C on its last tick
      chk("life_hold", 32'(mole), 32'(oh(idx_c) | oh(idx_d)));
      tick(idx);   // T14
      chk("expire_mole",   32'(mole),   32'(oh(idx_d)));
      chk("expire_misses", 32'(misses), 32'd1);
      chk("expire_score",  32'(score),  32'd1);
      tick(idx);   // T15
      idx_e = first_empty(oh(idx_d), idx);
      chk("spawn_e", 32'(mole), 32'(oh(idx_d) | oh(idx_e)));
      tick(idx);   // T16

      // Hit on D exactly on its expiry tick (T17): hit wins
      pre_tick();
      hit = oh(idx_d); step();
      chk("tie_score",  32'(score),  32'd2);
      chk("tie_misses", 32'(misses), 32'd1);
      chk("tie_mole",   32'(mole),   32'(oh(idx_e)));
      hit = 4'b0000;

      // Start rise while playing is ignored
      start = 1'b1; step();
      chk("restart_state", 32'(game_state), 32'd1);
      chk("restart_time",  32'(time_left),  32'd33);
      start = 1'b0; step();

      // Run out the round
      for (int t = 18; t <= 49; t++) tick(idx);
      chk("last_tick_time",  32'(time_left),  32'd1);
      chk("last_tick_state", 32'(game_state), 32'd1);
      tick(idx);   // T50
      chk("done_state", 32'(game_state), 32'd2);
      chk("done_over",  32'(game_over),  32'd1);
      chk("done_mole",  32'(mole),       32'd0);
      chk("done_time",  32'(time_left),  32'd0);
      chk("done_score", 32'(score),      32'd2);
      tick(idx); tick(idx);
      chk("done_hold_state", 32'(game_state), 32'd2);
      chk("done_hold_score", 32'(score),      32'd2);
      chk("done_hold_mole",  32'(mole),       32'd0);

      // Second instance: one spawn per tick fills the board, then a full-board spawn skips
      align();
      start2 = 1'b1; step();
      chk("d2_start", 32'(game_state2), 32'd1);
      start2 = 1'b0;
      for (int t = 1; t <= 4; t++) tick(idx);
      chk("d2_fill", 32'(mole2), 32'hF);
      tick(idx);   // T5
      chk("d2_full_skip", 32'(mole2), 32'hF);
      hit2 = 4'b1111; step();
      chk("d2_quad_score", 32'(score2), 32'd4);
      chk("d2_quad_mole",  32'(mole2),  32'd0);
      hit2 = 4'b0000;
      for (int t = 6; t <= 9; t++) tick(idx);
      chk("d2_refill", 32'(mole2), 32'hF);
      hit2 = 4'b1010; step();
      chk("d2_pair_score", 32'(score2), 32'd6);
      chk("d2_pair_mole",  32'(mole2),  32'h5);
      hit2 = 4'b0000;
      tick(idx);   // T10 refills hole 1 or 3
      hit2 = mole2 & 4'b1010; step();
      chk("d2_pre_score", 32'(score2), 32'd7);
      chk("d2_pre_mole",  32'(mole2),  32'h5);
      hit2 = 4'b0000;

      // Asynchronous reset mid-play, checked before any clock edge
      #2 reset = 1'b0;
      #1;
      chk("arst_mole",   32'(mole2),       32'd0);
      chk("arst_score",  32'(score2),      32'd0);
      chk("arst_misses", 32'(misses2),     32'd0);
      chk("arst_time",   32'(time_left2),  32'd0);
      chk("arst_state",  32'(game_state2), 32'd0);
      chk("arst_over",   32'(game_over2),  32'd0);
      chk("arst_d1_state", 32'(game_state), 32'd0);
      chk("arst_d1_over",  32'(game_over),  32'd0);
      chk("arst_lfsr",   32'(dut2.u_lfsr.lfsr_r), 32'h0000ACE1);
      @(negedge clk);
      reset = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
